// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Optional frame locking is enabled by defining UART_ARB_FRAME_EN.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       rstN,
   input  logic [NUM_REQ-1:0]         reqValid,
   input  logic [8*NUM_REQ-1:0]       reqData,
   input  logic [NUM_REQ-1:0]         reqLast,
   output logic [NUM_REQ-1:0]         reqReady,
   output logic [7:0]                 txData,
   output logic                       txStart,
   input  logic                       txIdle,
   output logic [$clog2(NUM_REQ)-1:0] grantId,
   output logic                       busy,
   output logic                       timeoutErr
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rrPtr_q, rrPtr_d;
   logic [ID_W-1:0]   grantId_q, grantId_d;
   logic [7:0]        txData_q, txData_d;
   logic              txStart_q, txStart_d;
   logic              timeoutErr_q, timeoutErr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [NUM_REQ-1:0] candMask;
   logic [ID_W:0]      idx;
   logic [ID_W-1:0]    winner;
   logic               found;
   logic [ID_W-1:0]    nextPtr;

`ifdef UART_ARB_FRAME_EN
   logic lockValid_q, lockValid_d;
`else
   logic unusedLast;
   assign unusedLast = ^reqLast;
`endif

   assign nextPtr = (grantId_q == ID_W'(NUM_REQ-1)) ? '0 : grantId_q + 1'b1;

   // Rotating priority search starting at rrPtr; explicit wrap covers non power-of-2 counts.
   always_comb begin
      candMask = reqValid;
`ifdef UART_ARB_FRAME_EN
      if (lockValid_q) candMask = reqValid & (NUM_REQ'(1) << grantId_q);
`endif
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, rrPtr_q} + (ID_W+1)'(k);
         if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
         if (!found && candMask[idx[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      reqReady = '0;
      if (rstN && state_q == IDLE && txIdle && found) reqReady = NUM_REQ'(1) << winner;
   end

   always_comb begin
      state_d      = state_q;
      rrPtr_d      = rrPtr_q;
      grantId_d    = grantId_q;
      txData_d     = txData_q;
      txStart_d    = txStart_q;
      timeoutErr_d = 1'b0;
      cnt_d        = cnt_q;
`ifdef UART_ARB_FRAME_EN
      lockValid_d  = lockValid_q;
`endif
      case (state_q)
         IDLE: begin
            if (txIdle && found) begin
               txData_d  = reqData[{winner, 3'b000} +: 8];
               grantId_d = winner;
               txStart_d = 1'b1;
               cnt_d     = '0;
               state_d   = LAUNCH;
`ifdef UART_ARB_FRAME_EN
               lockValid_d = !reqLast[winner];
`endif
            end
         end
         LAUNCH: begin
            if (!txIdle) begin
               txStart_d = 1'b0;
               state_d   = WAIT_DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
               txStart_d    = 1'b0;
               timeoutErr_d = 1'b1;
               state_d      = IDLE;
               rrPtr_d      = nextPtr;
`ifdef UART_ARB_FRAME_EN
               lockValid_d  = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (txIdle) begin
               state_d = IDLE;
`ifdef UART_ARB_FRAME_EN
               // A held lock keeps the pointer parked on the framing requester.
               if (!lockValid_q) rrPtr_d = nextPtr;
`else
               rrPtr_d = nextPtr;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q      <= IDLE;
         rrPtr_q      <= '0;
         grantId_q    <= '0;
         txData_q     <= '0;
         txStart_q    <= 1'b0;
         timeoutErr_q <= 1'b0;
         cnt_q        <= '0;
`ifdef UART_ARB_FRAME_EN
         lockValid_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         rrPtr_q      <= rrPtr_d;
         grantId_q    <= grantId_d;
         txData_q     <= txData_d;
         txStart_q    <= txStart_d;
         timeoutErr_q <= timeoutErr_d;
         cnt_q        <= cnt_d;
`ifdef UART_ARB_FRAME_EN
         lockValid_q  <= lockValid_d;
`endif
      end
   end

   assign txData     = txData_q;
   assign txStart    = txStart_q;
   assign grantId    = grantId_q;
   assign busy       = (state_q != IDLE);
   assign timeoutErr = timeoutErr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model driving txIdle.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ        = 4;
   localparam int TIMEOUT_CYCLES = 32;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic [3:0]  reqValid = '0;
   logic [31:0] reqData = '0;
   logic [3:0]  reqLast = '0;
   logic [3:0]  reqReady;
   logic [7:0]  txData;
   logic        txStart;
   logic        txIdle = 1'b1;
   logic [1:0]  grantId;
   logic        busy;
   logic        timeoutErr;

   int compared = 0;
   int mismatched = 0;

   int          remaining[4];
   logic [7:0]  nextByte[4];
   int          grantLog[16];
   logic [7:0]  txLog[16];
   logic [1:0]  gidLog[16];

   bit modelEn = 1'b1;
   int frameLen = 4;
   int modelCnt = 0;

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqData(reqData), .reqLast(reqLast),
      .reqReady(reqReady), .txData(txData), .txStart(txStart), .txIdle(txIdle),
      .grantId(grantId), .busy(busy), .timeoutErr(timeoutErr)
   );

   always #5 clk = ~clk;

   // Transmitter model: goes busy one cycle after seeing txStart, stays busy frameLen+1 cycles.
   always @(posedge clk) begin
      if (!txIdle) begin
         if (modelCnt == 0) txIdle <= 1'b1;
         else modelCnt <= modelCnt - 1;
      end else if (modelEn && txStart) begin
         txIdle   <= 1'b0;
         modelCnt <= frameLen;
      end
   end

   task automatic driveProducers();
      for (int i = 0; i < 4; i++) begin
         reqValid[i]        = (remaining[i] != 0);
         reqData[8*i +: 8]  = nextByte[i];
         reqLast[i]         = (remaining[i] == 1);
      end
   endtask

   task automatic clearProducers();
      for (int i = 0; i < 4; i++) begin
         remaining[i] = 0;
         nextByte[i]  = 8'h00;
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rstN = 1'b0;
      clearProducers();
      driveProducers();
      repeat (2) @(negedge clk);
      rstN = 1'b1;
   endtask

   task automatic waitIdle(input int maxCycles, input string tag);
      int c;
      for (c = 0; c < maxCycles; c++) begin
         @(negedge clk); driveProducers(); #1;
         if (!busy) break;
      end
      if (c >= maxCycles) begin
         mismatched++;
         $display("[TB] FAIL %s_idle_wait: busy still %b after %0d cycles, expected 0", tag, busy, maxCycles);
      end
   endtask

   task automatic collectGrants(input int n, input int maxCycles, output int got);
      logic [3:0] hs;
      int pend;
      pend = -1;
      got  = 0;
      for (int c = 0; c < maxCycles && got < n; c++) begin
         @(negedge clk); driveProducers(); #1;
         if (pend >= 0) begin
            txLog[pend] = txData; gidLog[pend] = grantId; pend = -1;
         end
         hs = reqValid & reqReady;
         for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
               grantLog[got] = i;
               pend = got;
               got++;
               if (remaining[i] > 0) remaining[i]--;
               nextByte[i] = nextByte[i] + 8'h01;
            end
         end
      end
      if (pend >= 0) begin
         @(negedge clk); driveProducers(); #1;
         txLog[pend] = txData; gidLog[pend] = grantId;
      end
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      for (int i = 0; i < 4; i++) begin remaining[i] = -1; nextByte[i] = 8'hF0; end
      driveProducers();
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      compared++; if (reqReady !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_reqReady: got %b expected 0000", reqReady); end
      compared++; if (txStart !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_txStart: got %b expected 0", txStart); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      compared++; if (grantId !== 2'd0 || txData !== 8'h00 || timeoutErr !== 1'b0) begin
         mismatched++; $display("[TB] FAIL reset_regs: got grantId=%0d txData=%h timeoutErr=%b expected 0/00/0", grantId, txData, timeoutErr);
      end
      clearProducers(); driveProducers();
      rstN = 1'b1;
   endtask

   task automatic test_single();
      int c;
      remaining[1] = 1; nextByte[1] = 8'hA5;
      @(negedge clk); driveProducers(); #1;
      compared++; if (reqReady !== 4'b0010) begin mismatched++; $display("[TB] FAIL single_ready: got %b expected 0010", reqReady); end
      remaining[1] = 0;
      @(negedge clk); driveProducers(); #1;
      compared++; if (txStart !== 1'b1 || txData !== 8'hA5 || grantId !== 2'd1) begin
         mismatched++; $display("[TB] FAIL single_launch: got txStart=%b txData=%h grantId=%0d expected 1/a5/1", txStart, txData, grantId);
      end
      compared++; if (reqReady !== 4'b0000 || busy !== 1'b1) begin
         mismatched++; $display("[TB] FAIL single_oneshot: got reqReady=%b busy=%b expected 0000/1", reqReady, busy);
      end
      for (c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         if (!txStart) break;
      end
      compared++; if (c >= 20 || txIdle !== 1'b0 || txData !== 8'hA5) begin
         mismatched++; $display("[TB] FAIL single_start_drop: got txIdle=%b txData=%h after %0d cycles expected 0/a5", txIdle, txData, c);
      end
      waitIdle(40, "single");
      compared++; if (txIdle !== 1'b1 || txStart !== 1'b0) begin
         mismatched++; $display("[TB] FAIL single_done: got txIdle=%b txStart=%b expected 1/0", txIdle, txStart);
      end
   endtask

   task automatic test_fairness();
      int got;
      doReset();
      for (int i = 0; i < 4; i++) begin remaining[i] = -1; nextByte[i] = 8'(i * 16); end
      collectGrants(8, 400, got);
      compared++; if (got !== 8) begin mismatched++; $display("[TB] FAIL fair_count: got %0d grants expected 8", got); end
      for (int k = 0; k < got && k < 8; k++) begin
         compared++;
         if (grantLog[k] !== (k % 4) || gidLog[k] !== 2'(k % 4) || txLog[k] !== 8'(16 * (k % 4) + k / 4)) begin
            mismatched++;
            $display("[TB] FAIL fair_grant%0d: got req=%0d grantId=%0d txData=%h expected %0d/%0d/%h",
                     k, grantLog[k], gidLog[k], txLog[k], k % 4, k % 4, 8'(16 * (k % 4) + k / 4));
         end
      end
      clearProducers();
      waitIdle(40, "fair");
   endtask

   task automatic test_timeout();
      int c;
      modelEn = 1'b0;
      doReset();
      remaining[0] = 1; nextByte[0] = 8'h40;
      remaining[1] = 1; nextByte[1] = 8'h41;
      @(negedge clk); driveProducers(); #1;
      compared++; if (reqReady !== 4'b0001) begin mismatched++; $display("[TB] FAIL tmo_first_ready: got %b expected 0001", reqReady); end
      remaining[0] = 0;
      for (c = 1; c <= TIMEOUT_CYCLES + 10; c++) begin
         @(negedge clk); driveProducers(); #1;
         if (timeoutErr) break;
      end
      compared++; if (c - 1 !== TIMEOUT_CYCLES) begin
         mismatched++; $display("[TB] FAIL tmo_latency: got pulse %0d cycles after accept expected %0d", c - 1, TIMEOUT_CYCLES);
      end
      compared++; if (reqReady !== 4'b0010 || txStart !== 1'b0) begin
         mismatched++; $display("[TB] FAIL tmo_next_grant: got reqReady=%b txStart=%b expected 0010/0", reqReady, txStart);
      end
      remaining[1] = 0;
      @(negedge clk); driveProducers(); #1;
      compared++; if (timeoutErr !== 1'b0 || grantId !== 2'd1 || txData !== 8'h41) begin
         mismatched++; $display("[TB] FAIL tmo_pulse_end: got timeoutErr=%b grantId=%0d txData=%h expected 0/1/41", timeoutErr, grantId, txData);
      end
      waitIdle(2 * TIMEOUT_CYCLES + 10, "tmo");
      modelEn = 1'b1;
   endtask

   task automatic test_midop_reset();
      int got;
      int c;
      frameLen = 10;
      doReset();
      remaining[2] = 1; nextByte[2] = 8'h77;
      collectGrants(1, 20, got);
      for (c = 0; c < 20; c++) begin
         @(negedge clk); driveProducers(); #1;
         if (busy && !txStart) break;
      end
      compared++; if (got !== 1 || c >= 20) begin
         mismatched++; $display("[TB] FAIL midrst_reach_wait: got grants=%0d cycles=%0d expected 1 grant and WAIT_DONE", got, c);
      end
      remaining[3] = -1; nextByte[3] = 8'h33;
      driveProducers();
      rstN = 1'b0;
      @(negedge clk); #1;
      compared++; if (busy !== 1'b0 || txStart !== 1'b0 || txData !== 8'h00 || grantId !== 2'd0 || reqReady !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL midrst_state: got busy=%b txStart=%b txData=%h grantId=%0d reqReady=%b expected 0/0/00/0/0000",
                  busy, txStart, txData, grantId, reqReady);
      end
      rstN = 1'b1;
      remaining[0] = 1; nextByte[0] = 8'h55;
      for (c = 0; c < 40; c++) begin
         @(negedge clk); driveProducers(); #1;
         if (reqReady != 4'b0000) break;
      end
      compared++; if (reqReady !== 4'b0001) begin
         mismatched++; $display("[TB] FAIL midrst_rrptr: got reqReady=%b expected 0001", reqReady);
      end
      remaining[0] = 0; remaining[3] = 0;
      @(negedge clk); driveProducers();
      waitIdle(40, "midrst");
      frameLen = 4;
   endtask

   task automatic test_frame();
      int got;
      int expG[5];
      logic [7:0] expD[5];
`ifdef UART_ARB_FRAME_EN
      expG = '{2, 2, 2, 0, 0};
      expD = '{8'h20, 8'h21, 8'h22, 8'h00, 8'h01};
`else
      expG = '{2, 0, 2, 0, 2};
      expD = '{8'h20, 8'h00, 8'h21, 8'h01, 8'h22};
`endif
      doReset();
      remaining[1] = 1; nextByte[1] = 8'h11;
      collectGrants(1, 20, got);
      waitIdle(40, "frame_pre");
      remaining[2] = 3;  nextByte[2] = 8'h20;
      remaining[0] = -1; nextByte[0] = 8'h00;
      collectGrants(5, 300, got);
      compared++; if (got !== 5) begin mismatched++; $display("[TB] FAIL frame_count: got %0d grants expected 5", got); end
      for (int k = 0; k < got && k < 5; k++) begin
         compared++;
         if (grantLog[k] !== expG[k] || txLog[k] !== expD[k]) begin
            mismatched++;
            $display("[TB] FAIL frame_grant%0d: got req=%0d txData=%h expected %0d/%h", k, grantLog[k], txLog[k], expG[k], expD[k]);
         end
      end
      clearProducers();
      waitIdle(40, "frame");
   endtask

   initial begin
      clearProducers();
      test_reset();
      test_single();
      test_fairness();
      test_timeout();
      test_midop_reset();
      test_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
